// File: rtl/calc_sequencer_if.sv
// calc_sequencer_if
//   Bundles the key handshake from input_control, the arithmetic-unit request
//   and response, and the display/status outputs of the calculator sequencer.
//   master : the sequencer side (drives KeyRd, OpA/OpB/AluOp/AluStart,
//            DispValue, Busy, Error).
//   slave  : the environment side (drives the key fields, KeyRdy and the
//            ALU response).
interface calc_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             KeyRdy;
    logic             KeyRd;
    logic [3:0]       Number;
    logic [2:0]       Operator;
    logic             EqualSign;
    logic [WIDTH-1:0] OpA;
    logic [WIDTH-1:0] OpB;
    logic [2:0]       AluOp;
    logic             AluStart;
    logic             AluDone;
    logic [WIDTH-1:0] AluResult;
    logic             AluErr;
    logic [WIDTH-1:0] DispValue;
    logic             Busy;
    logic             Error;

    modport master (
        input  KeyRdy, Number, Operator, EqualSign, AluDone, AluResult, AluErr,
        output KeyRd, OpA, OpB, AluOp, AluStart, DispValue, Busy, Error
    );

    modport slave (
        output KeyRdy, Number, Operator, EqualSign, AluDone, AluResult, AluErr,
        input  KeyRd, OpA, OpB, AluOp, AluStart, DispValue, Busy, Error
    );
endinterface

// File: rtl/calc_sequencer.sv
// calc_sequencer
//   Top-level sequencer of the 16-bit signed calculator. Accepts key events
//   over the KeyRdy/KeyRd handshake, builds two signed decimal operands,
//   launches one ALU operation at a time (with operator chaining) and drives
//   the display value and the error flag.
// Ports:
//   Clock  : system clock
//   Reset  : asynchronous reset, active low
//   bus    : calc_sequencer_if.master (key handshake, ALU request/response,
//            DispValue, Busy, Error)
// Build option:
//   CALC_SEQ_ANS_EN : when defined, adds an "ans" register holding the last
//                     successful result, recalled by operator 111.
module calc_sequencer #(
    parameter int WIDTH       = 16,
    parameter int MAX_DIGITS  = 5,
    parameter int ALU_TIMEOUT = 255
) (
    input  logic             Clock,
    input  logic             Reset,
    calc_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_ENTER_A  = 3'd0,
        S_OP_WAIT  = 3'd1,
        S_ENTER_B  = 3'd2,
        S_EXEC     = 3'd3,
        S_WAIT_ALU = 3'd4,
        S_SHOW     = 3'd5,
        S_ERROR    = 3'd6
    } state_e;

    localparam logic [2:0]       MAX_CNT   = 3'(MAX_DIGITS);
    localparam logic [7:0]       TMO_LAST  = 8'(ALU_TIMEOUT - 1);
    localparam logic [WIDTH+3:0] MAG_LIMIT = {5'b00000, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] ZERO      = {WIDTH{1'b0}};

    // Two's complement negate.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ZERO - x;
    endfunction

    // Appends decimal digit d to the magnitude of x keeping its sign.
    // Returns {too_big, new_value}.
    function automatic logic [WIDTH:0] append_digit(input logic [WIDTH-1:0] x,
                                                    input logic [3:0]       d);
        logic [WIDTH-1:0] mag;
        logic [WIDTH+3:0] grown;
        logic [WIDTH-1:0] val;
        mag   = x[WIDTH-1] ? negate(x) : x;
        grown = ({4'b0000, mag} << 3'd3) + ({4'b0000, mag} << 3'd1) + {ZERO, d};
        val   = x[WIDTH-1] ? negate(grown[WIDTH-1:0]) : grown[WIDTH-1:0];
        return {(grown > MAG_LIMIT), val};
    endfunction

    state_e           state_q, state_d;
    logic             armed_q, armed_d;
    logic             key_rd_q, key_rd_d;
    logic             key_vld_q, key_vld_d;
    logic [3:0]       key_num_q, key_num_d;
    logic [2:0]       key_op_q, key_op_d;
    logic             key_eq_q, key_eq_d;
    logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d, disp_q, disp_d;
    logic [2:0]       alu_op_q, alu_op_d, pending_op_q, pending_op_d;
    logic             alu_start_q, alu_start_d, busy_q, busy_d, error_q, error_d;
    logic             chain_q, chain_d;
    logic [2:0]       count_q, count_d;
    logic [7:0]       tmo_cnt_q, tmo_cnt_d;

    logic             accept_s, k_eq_s, k_opkey_s, k_arith_s, k_clear_s;
    logic             k_sign_s, k_ans_s, k_digit_s, alu_ok_s, digit_room_s;
    logic [WIDTH:0]   a_app_s, b_app_s;
    logic [WIDTH-1:0] ans_val_s, digit_val_s;

    // Keys are taken only in the key-consuming states and only once per
    // KeyRdy assertion; the latched key is decoded one cycle later.
    assign accept_s  = bus.KeyRdy && armed_q &&
                       (state_q inside {S_ENTER_A, S_OP_WAIT, S_ENTER_B, S_SHOW, S_ERROR});
    assign k_eq_s    = key_vld_q && key_eq_q;
    assign k_opkey_s = key_vld_q && !key_eq_q && (key_op_q != 3'b000);
    assign k_arith_s = k_opkey_s && (key_op_q inside {3'b001, 3'b010, 3'b011, 3'b100});
    assign k_clear_s = k_opkey_s && (key_op_q == 3'b101);
    assign k_sign_s  = k_opkey_s && (key_op_q == 3'b110);
    assign k_digit_s = key_vld_q && !key_eq_q && (key_op_q == 3'b000) && (key_num_q <= 4'd9);
    assign alu_ok_s  = (state_q == S_WAIT_ALU) && bus.AluDone && !bus.AluErr;
    assign a_app_s   = append_digit(op_a_q, key_num_q);
    assign b_app_s   = append_digit(op_b_q, key_num_q);
    assign digit_room_s = (count_q < MAX_CNT);
    assign digit_val_s  = {{(WIDTH-4){1'b0}}, key_num_q};

`ifdef CALC_SEQ_ANS_EN
    logic [WIDTH-1:0] ans_q, ans_d;
    assign k_ans_s   = k_opkey_s && (key_op_q == 3'b111);
    assign ans_val_s = ans_q;

    // ans follows every successful ALU result; Clear wipes it.
    always_comb begin
        if (k_clear_s) begin
            ans_d = ZERO;
        end else if (alu_ok_s) begin
            ans_d = bus.AluResult;
        end else begin
            ans_d = ans_q;
        end
    end

    // ans register.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) ans_q <= ZERO;
        else        ans_q <= ans_d;
    end
`else
    assign k_ans_s   = 1'b0;
    assign ans_val_s = ZERO;
`endif

    // Next-state and output decode.
    always_comb begin
        state_d      = state_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        disp_d       = disp_q;
        alu_op_d     = alu_op_q;
        pending_op_d = pending_op_q;
        chain_d      = chain_q;
        count_d      = count_q;
        tmo_cnt_d    = tmo_cnt_q;
        key_rd_d     = accept_s;
        key_vld_d    = accept_s;
        alu_start_d  = (state_q == S_EXEC);
        if (accept_s) begin
            key_num_d = bus.Number;
            key_op_d  = bus.Operator;
            key_eq_d  = bus.EqualSign;
            armed_d   = 1'b0;
        end else begin
            key_num_d = key_num_q;
            key_op_d  = key_op_q;
            key_eq_d  = key_eq_q;
            armed_d   = armed_q || !bus.KeyRdy;
        end

        if (k_clear_s) begin
            state_d      = S_ENTER_A;
            op_a_d       = ZERO;
            op_b_d       = ZERO;
            disp_d       = ZERO;
            alu_op_d     = 3'b000;
            pending_op_d = 3'b000;
            chain_d      = 1'b0;
            count_d      = 3'd0;
            tmo_cnt_d    = 8'd0;
        end else begin
            case (state_q)
                S_ENTER_A: begin
                    if (k_digit_s && digit_room_s && !a_app_s[WIDTH]) begin
                        op_a_d  = a_app_s[WIDTH-1:0];
                        disp_d  = a_app_s[WIDTH-1:0];
                        count_d = count_q + 3'd1;
                    end else if (k_sign_s) begin
                        op_a_d = negate(op_a_q);
                        disp_d = negate(op_a_q);
                    end else if (k_arith_s) begin
                        alu_op_d = key_op_q;
                        state_d  = S_OP_WAIT;
                    end else if (k_ans_s) begin
                        op_a_d  = ans_val_s;
                        disp_d  = ans_val_s;
                        count_d = MAX_CNT;
                    end else begin
                        state_d = state_q;
                    end
                end
                S_OP_WAIT: begin
                    if (k_arith_s) begin
                        alu_op_d = key_op_q;
                    end else if (k_digit_s) begin
                        op_b_d  = digit_val_s;
                        disp_d  = digit_val_s;
                        count_d = 3'd1;
                        state_d = S_ENTER_B;
                    end else if (k_ans_s) begin
                        op_b_d  = ans_val_s;
                        disp_d  = ans_val_s;
                        count_d = MAX_CNT;
                        state_d = S_ENTER_B;
                    end else begin
                        state_d = state_q;
                    end
                end
                S_ENTER_B: begin
                    if (k_digit_s && digit_room_s && !b_app_s[WIDTH]) begin
                        op_b_d  = b_app_s[WIDTH-1:0];
                        disp_d  = b_app_s[WIDTH-1:0];
                        count_d = count_q + 3'd1;
                    end else if (k_sign_s) begin
                        op_b_d = negate(op_b_q);
                        disp_d = negate(op_b_q);
                    end else if (k_eq_s) begin
                        chain_d = 1'b0;
                        state_d = S_EXEC;
                    end else if (k_arith_s) begin
                        chain_d      = 1'b1;
                        pending_op_d = key_op_q;
                        state_d      = S_EXEC;
                    end else if (k_ans_s) begin
                        op_b_d  = ans_val_s;
                        disp_d  = ans_val_s;
                        count_d = MAX_CNT;
                    end else begin
                        state_d = state_q;
                    end
                end
                S_EXEC: begin
                    tmo_cnt_d = 8'd0;
                    state_d   = S_WAIT_ALU;
                end
                S_WAIT_ALU: begin
                    if (bus.AluDone && bus.AluErr) begin
                        disp_d  = ZERO;
                        state_d = S_ERROR;
                    end else if (bus.AluDone) begin
                        disp_d = bus.AluResult;
                        if (chain_q) begin
                            op_a_d   = bus.AluResult;
                            alu_op_d = pending_op_q;
                            chain_d  = 1'b0;
                            state_d  = S_OP_WAIT;
                        end else begin
                            state_d = S_SHOW;
                        end
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        disp_d  = ZERO;
                        state_d = S_ERROR;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 8'd1;
                    end
                end
                S_SHOW: begin
                    // In SHOW the display register holds the last result.
                    if (k_digit_s) begin
                        op_a_d  = digit_val_s;
                        disp_d  = digit_val_s;
                        count_d = 3'd1;
                        state_d = S_ENTER_A;
                    end else if (k_arith_s) begin
                        op_a_d   = disp_q;
                        alu_op_d = key_op_q;
                        state_d  = S_OP_WAIT;
                    end else if (k_eq_s) begin
                        op_a_d  = disp_q;
                        chain_d = 1'b0;
                        state_d = S_EXEC;
                    end else if (k_sign_s) begin
                        // A negated result cannot take further digits.
                        op_a_d  = negate(disp_q);
                        disp_d  = negate(disp_q);
                        count_d = MAX_CNT;
                        state_d = S_ENTER_A;
                    end else begin
                        state_d = state_q;
                    end
                end
                S_ERROR: begin
                    disp_d = ZERO;
                end
                default: begin
                    state_d = S_ENTER_A;
                end
            endcase
        end

        busy_d  = (state_d == S_EXEC) || (state_d == S_WAIT_ALU);
        error_d = (state_d == S_ERROR);
    end

    // State and datapath registers.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q      <= S_ENTER_A;
            armed_q      <= 1'b1;
            key_rd_q     <= 1'b0;
            key_vld_q    <= 1'b0;
            key_num_q    <= 4'd0;
            key_op_q     <= 3'b000;
            key_eq_q     <= 1'b0;
            op_a_q       <= ZERO;
            op_b_q       <= ZERO;
            disp_q       <= ZERO;
            alu_op_q     <= 3'b000;
            pending_op_q <= 3'b000;
            alu_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
            chain_q      <= 1'b0;
            count_q      <= 3'd0;
            tmo_cnt_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            armed_q      <= armed_d;
            key_rd_q     <= key_rd_d;
            key_vld_q    <= key_vld_d;
            key_num_q    <= key_num_d;
            key_op_q     <= key_op_d;
            key_eq_q     <= key_eq_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            disp_q       <= disp_d;
            alu_op_q     <= alu_op_d;
            pending_op_q <= pending_op_d;
            alu_start_q  <= alu_start_d;
            busy_q       <= busy_d;
            error_q      <= error_d;
            chain_q      <= chain_d;
            count_q      <= count_d;
            tmo_cnt_q    <= tmo_cnt_d;
        end
    end

    assign bus.KeyRd     = key_rd_q;
    assign bus.OpA       = op_a_q;
    assign bus.OpB       = op_b_q;
    assign bus.AluOp     = alu_op_q;
    assign bus.AluStart  = alu_start_q;
    assign bus.DispValue = disp_q;
    assign bus.Busy      = busy_q;
    assign bus.Error     = error_q;
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer
//   Self-checking bench for calc_sequencer. Expected ALU requests (and the
//   response the bench ALU returns for each) are queued when the key
//   sequence is driven and compared when the DUT pulses AluStart.
module tb_calc_sequencer;
    localparam logic [2:0] OP_ADD = 3'b001, OP_SUB = 3'b010, OP_MUL = 3'b011;
    localparam logic [2:0] OP_DIV = 3'b100, OP_CLR = 3'b101, OP_SGN = 3'b110;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
        logic [15:0] res;
        logic        err;
        int          dly;
        bit          respond;
        bit          chk;
    } alu_txn_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   keyrd_cnt;
    int   base_cnt;
    alu_txn_t sb_q[$];

    calc_sequencer_if #(.WIDTH(16)) bus ();

    calc_sequencer dut (
        .Clock (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_txn(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                            input logic [15:0] res, input logic err, input int dly,
                            input bit respond, input bit chk);
        alu_txn_t t;
        t.a = a; t.b = b; t.op = op; t.res = res; t.err = err;
        t.dly = dly; t.respond = respond; t.chk = chk;
        sb_q.push_back(t);
    endtask

    // Raise KeyRdy, wait for the acknowledge, then release the key.
    task automatic press(input logic [3:0] n, input logic [2:0] op, input logic eq);
        int t;
        @(posedge clk); #1;
        bus.Number = n; bus.Operator = op; bus.EqualSign = eq; bus.KeyRdy = 1'b1;
        t = 0;
        while (bus.KeyRd !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) check_eq("keyrd_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.KeyRdy = 1'b0; bus.Number = 4'd0; bus.Operator = 3'b000; bus.EqualSign = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic digit(input logic [3:0] n);
        press(n, 3'b000, 1'b0);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while (bus.Busy === 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) check_eq("idle_timeout", 32'd1, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // KeyRd pulse counter.
    always @(negedge clk) begin
        if (bus.KeyRd === 1'b1) keyrd_cnt++;
    end

    // Bench ALU: checks each request against the scoreboard and answers it.
    initial begin
        alu_txn_t t;
        bus.AluDone = 1'b0; bus.AluResult = 16'h0000; bus.AluErr = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.AluStart === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check_eq("alu_unexpected_start", 32'd1, 32'd0);
                end else begin
                    t = sb_q.pop_front();
                    check_eq("alu_opa", bus.OpA, t.a);
                    check_eq("alu_opb", bus.OpB, t.b);
                    check_eq("alu_op", bus.AluOp, t.op);
                    if (t.respond) begin
                        repeat (t.dly) @(posedge clk);
                        #1;
                        bus.AluDone = 1'b1; bus.AluResult = t.res; bus.AluErr = t.err;
                        @(posedge clk); #1;
                        bus.AluDone = 1'b0; bus.AluErr = 1'b0;
                        if (t.chk) begin
                            check_eq("disp_after_done", bus.DispValue, t.err ? 16'h0000 : t.res);
                            check_eq("err_after_done", bus.Error, t.err);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog");
        $fatal(1);
    end

    initial begin
        checks = 0; errors = 0; keyrd_cnt = 0;
        rst_n = 1'b0;
        bus.KeyRdy = 1'b0; bus.Number = 4'd0; bus.Operator = 3'b000; bus.EqualSign = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_disp", bus.DispValue, 16'h0000);
        check_eq("rst_busy", bus.Busy, 1'b0);
        check_eq("rst_error", bus.Error, 1'b0);
        check_eq("rst_keyrd", bus.KeyRd, 1'b0);
        check_eq("rst_opa", bus.OpA, 16'h0000);
        check_eq("rst_aluop", bus.AluOp, 3'b000);

        // 12 + 3 = 15, then '=' repeats the add on the result.
        digit(4'd1); digit(4'd2);
        check_eq("entry_12", bus.DispValue, 16'd12);
        press(4'd0, OP_ADD, 1'b0);
        digit(4'd3);
        check_eq("entry_b3", bus.DispValue, 16'd3);
        push_txn(16'd12, 16'd3, OP_ADD, 16'd15, 1'b0, 4, 1'b1, 1'b1);
        press(4'd0, 3'b000, 1'b1);
        wait_idle();
        check_eq("add_disp", bus.DispValue, 16'd15);
        push_txn(16'd15, 16'd3, OP_ADD, 16'd18, 1'b0, 2, 1'b1, 1'b1);
        press(4'd0, 3'b000, 1'b1);
        wait_idle();
        check_eq("repeat_disp", bus.DispValue, 16'd18);

        // -5 * 4 = -20.
        press(4'd0, OP_CLR, 1'b0);
        check_eq("clr_disp", bus.DispValue, 16'h0000);
        digit(4'd5);
        press(4'd0, OP_SGN, 1'b0);
        check_eq("sign_disp", bus.DispValue, 16'hFFFB);
        press(4'd0, OP_MUL, 1'b0);
        digit(4'd4);
        push_txn(16'hFFFB, 16'd4, OP_MUL, 16'hFFEC, 1'b0, 3, 1'b1, 1'b1);
        press(4'd0, 3'b000, 1'b1);
        wait_idle();
        check_eq("mul_disp", bus.DispValue, 16'hFFEC);

        // Chain 2 + 3 - 1 =.
        press(4'd0, OP_CLR, 1'b0);
        digit(4'd2); press(4'd0, OP_ADD, 1'b0); digit(4'd3);
        push_txn(16'd2, 16'd3, OP_ADD, 16'd5, 1'b0, 4, 1'b1, 1'b1);
        press(4'd0, OP_SUB, 1'b0);
        digit(4'd1);
        push_txn(16'd5, 16'd1, OP_SUB, 16'd4, 1'b0, 4, 1'b1, 1'b1);
        press(4'd0, 3'b000, 1'b1);
        wait_idle();
        check_eq("chain_disp", bus.DispValue, 16'd4);

        // Magnitude limit: 32768 and 32769 are rejected.
        press(4'd0, OP_CLR, 1'b0);
        digit(4'd3); digit(4'd2); digit(4'd7); digit(4'd6); digit(4'd8); digit(4'd9);
        check_eq("mag_limit", bus.DispValue, 16'd3276);
        // Digit-count limit: sixth digit is dropped.
        press(4'd0, OP_CLR, 1'b0);
        digit(4'd1); digit(4'd2); digit(4'd3); digit(4'd4); digit(4'd5); digit(4'd6);
        check_eq("count_limit", bus.DispValue, 16'd12345);

        // Divide by zero -> ERROR; digits ignored; Clear recovers.
        press(4'd0, OP_CLR, 1'b0);
        digit(4'd8); press(4'd0, OP_DIV, 1'b0); digit(4'd0);
        push_txn(16'd8, 16'd0, OP_DIV, 16'h1234, 1'b1, 3, 1'b1, 1'b1);
        press(4'd0, 3'b000, 1'b1);
        wait_idle();
        check_eq("err_flag", bus.Error, 1'b1);
        base_cnt = keyrd_cnt;
        digit(4'd7);
        check_eq("err_ack", keyrd_cnt - base_cnt, 32'd1);
        check_eq("err_hold", bus.Error, 1'b1);
        check_eq("err_disp", bus.DispValue, 16'h0000);
        press(4'd0, OP_CLR, 1'b0);
        check_eq("err_clear", bus.Error, 1'b0);
        digit(4'd6);
        check_eq("after_clear_digit", bus.DispValue, 16'd6);

        // ALU never answers -> timeout ERROR.
        press(4'd0, OP_CLR, 1'b0);
        digit(4'd1); press(4'd0, OP_ADD, 1'b0); digit(4'd1);
        push_txn(16'd1, 16'd1, OP_ADD, 16'd0, 1'b0, 0, 1'b0, 1'b0);
        press(4'd0, 3'b000, 1'b1);
        wait_idle();
        check_eq("timeout_err", bus.Error, 1'b1);
        press(4'd0, OP_CLR, 1'b0);

        // KeyRdy held five cycles gives one acknowledge; code 12 is discarded.
        base_cnt = keyrd_cnt;
        @(posedge clk); #1;
        bus.Number = 4'd7; bus.KeyRdy = 1'b1;
        repeat (5) @(posedge clk);
        #1 bus.KeyRdy = 1'b0; bus.Number = 4'd0;
        repeat (3) @(posedge clk);
        check_eq("held_one_ack", keyrd_cnt - base_cnt, 32'd1);
        check_eq("held_disp", bus.DispValue, 16'd7);
        base_cnt = keyrd_cnt;
        digit(4'd12);
        check_eq("bad_num_ack", keyrd_cnt - base_cnt, 32'd1);
        check_eq("bad_num_disp", bus.DispValue, 16'd7);

        // Reset during WAIT_ALU; the late AluDone must be ignored.
        press(4'd0, OP_CLR, 1'b0);
        digit(4'd1); press(4'd0, OP_ADD, 1'b0); digit(4'd2);
        push_txn(16'd1, 16'd2, OP_ADD, 16'd3, 1'b0, 12, 1'b1, 1'b0);
        press(4'd0, 3'b000, 1'b1);
        check_eq("busy_in_wait", bus.Busy, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("arst_busy", bus.Busy, 1'b0);
        check_eq("arst_opa", bus.OpA, 16'h0000);
        check_eq("arst_aluop", bus.AluOp, 3'b000);
        check_eq("arst_disp", bus.DispValue, 16'h0000);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check_eq("late_done_disp", bus.DispValue, 16'h0000);
        check_eq("late_done_err", bus.Error, 1'b0);
        check_eq("late_done_busy", bus.Busy, 1'b0);
        digit(4'd4);
        check_eq("post_rst_digit", bus.DispValue, 16'd4);

        check_eq("sb_empty", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
